jtag_host: RTL and testbench

Host-side JTAG driver: turns single-word scan commands into TCK/TMS/TDI waveforms for a 1149.1 TAP and returns the captured TDO bits. It sits between the on-chip test controller and the TAP pins, and drives IR scans, DR scans, TAP reset and Run-Test/Idle clocking. It tracks the target TAP state internally and always parks the TAP in Run-Test/Idle between commands.

---
 rtl/jtag_host.sv | 184 ++++++++++++++++++
 tb/tb_jtag_host.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - host-side JTAG scan driver with TAP sequencing and TDO capture
module jtag_host #(
    parameter int MAX_LEN = 32,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int IW = $clog2(MAX_LEN + 8);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;

    typedef enum logic [1:0] {AUTO_RST, IDLE, RUN_SEQ, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          op_q;
    logic [IW-1:0]       len_q;
    logic [IW-1:0]       idx;
    logic [MAX_LEN-1:0]  data_q;
    logic                lead;
    logic [IW-1:0]       len_eff;
    logic [IW-1:0]       nxt_idx;
    logic [PW-1:0]       cur_pos;
    logic [PW-1:0]       nxt_pos;
    logic                cur_shift;
    logic                nxt_shift;
    logic                cur_last;
    logic                nxt_tms;

    // Rises spent walking from Run-Test/Idle into the shift state.
    function automatic logic [IW-1:0] seq_pre(input logic [1:0] op);
        case (op)
            OP_IR:   seq_pre = IW'(4);
            OP_DR:   seq_pre = IW'(3);
            default: seq_pre = '0;
        endcase
    endfunction

    function automatic logic is_scan(input logic [1:0] op);
        is_scan = (op == OP_IR) || (op == OP_DR);
    endfunction

    function automatic logic [IW-1:0] seq_total(input logic [1:0] op, input logic [IW-1:0] len);
        case (op)
            OP_RST:  seq_total = IW'(6);
            OP_IR:   seq_total = len + IW'(6);
            OP_DR:   seq_total = len + IW'(5);
            default: seq_total = len;
        endcase
    endfunction

    function automatic logic in_shift(input logic [1:0] op, input logic [IW-1:0] len,
                                      input logic [IW-1:0] i);
        in_shift = is_scan(op) && (i >= seq_pre(op)) && (i < seq_pre(op) + len);
    endfunction

    function automatic logic seq_tms(input logic [1:0] op, input logic [IW-1:0] len,
                                     input logic [IW-1:0] i);
        logic [IW-1:0] post;
        post    = seq_pre(op) + len;
        seq_tms = 1'b0;
        case (op)
            OP_RST: seq_tms = (i < IW'(5));
            OP_IR, OP_DR: begin
                // Leading ones select DR (and IR); the last shift bit exits, then Update, Idle.
                if (i < seq_pre(op) - IW'(2))
                    seq_tms = 1'b1;
                else if (i < post)
                    seq_tms = (i == post - IW'(1));
                else
                    seq_tms = (i == post);
            end
            default: seq_tms = 1'b0;
        endcase
    endfunction

    always_comb begin
        len_eff = IW'(cmd_len);
        if (cmd_len == '0)
            len_eff = IW'(1);
        else if (IW'(cmd_len) > IW'(MAX_LEN))
            len_eff = IW'(MAX_LEN);
    end

    always_comb begin
        nxt_idx   = lead ? '0 : idx + IW'(1);
        cur_shift = in_shift(op_q, len_q, idx);
        nxt_shift = in_shift(op_q, len_q, nxt_idx);
        cur_pos   = PW'(idx - seq_pre(op_q));
        nxt_pos   = PW'(nxt_idx - seq_pre(op_q));
        cur_last  = (idx == seq_total(op_q, len_q) - IW'(1));
        nxt_tms   = seq_tms(op_q, len_q, nxt_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= AUTO_RST;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AUTO_RST: if (tck && cur_last) state_nxt = IDLE;
            IDLE:     if (cmd_valid) state_nxt = RUN_SEQ;
            RUN_SEQ:  if (tck && cur_last) state_nxt = is_scan(op_q) ? RESP : IDLE;
            RESP:     if (rsp_ready) state_nxt = IDLE;
            default:  state_nxt = AUTO_RST;
        endcase
    end

    // Reset values already present rise 0 of the TAP reset sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            op_q     <= OP_RST;
            len_q    <= IW'(1);
            data_q   <= '0;
            idx      <= '0;
            lead     <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        len_q    <= len_eff;
                        data_q   <= cmd_data;
                        idx      <= '0;
                        lead     <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                AUTO_RST, RUN_SEQ: begin
                    if (lead) begin
                        lead <= 1'b0;
                        tms  <= nxt_tms;
                        tdi  <= nxt_shift & data_q[nxt_pos];
                    end else if (!tck) begin
                        tck <= 1'b1;
                        if (cur_shift)
                            rsp_data[cur_pos] <= tdo;
                    end else begin
                        tck <= 1'b0;
                        if (cur_last) begin
                            tms <= 1'b0;
                            tdi <= 1'b0;
                        end else begin
                            idx <= nxt_idx;
                            tms <= nxt_tms;
                            tdi <= nxt_shift & data_q[nxt_pos];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state == AUTO_RST) || (state == RUN_SEQ);

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - randomized bench for jtag_host with a waveform-level reference model
module tb_jtag_host;
    localparam int MAX_LEN = 32;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIS = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo;

    always #5 clk = ~clk;

    jtag_host #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Target side: a TAP state tracker with a 1-bit BYPASS register, or random / tied-high TDO.
    int   tap_st   = TLR;
    logic byp      = 1'b0;
    logic tdo_byp  = 1'b0;
    logic tdo_rnd  = 1'b0;
    int   tdo_mode = 0;
    bit   rise_tms[$];
    bit   rise_tdi[$];

    function automatic int tap_next(input int s, input bit m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDS  : RTI;
            SDS:  return m ? SIS  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDS  : RTI;
            SIS:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        rise_tms.push_back(tms);
        rise_tdi.push_back(tdi);
        if (tap_st == CDR)
            byp <= 1'b0;
        else if (tap_st == SHDR)
            byp <= tdi;
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        tdo_byp <= byp;
        tdo_rnd <= 1'($urandom);
    end

    assign tdo = (tdo_mode == 0) ? tdo_byp : (tdo_mode == 1) ? tdo_rnd : 1'b1;

    function automatic logic [63:0] pack_tms();
        logic [63:0] r = '0;
        foreach (rise_tms[i]) if (i < 64) r[i] = rise_tms[i];
        return r;
    endfunction

    function automatic logic [63:0] pack_tdi();
        logic [63:0] r = '0;
        foreach (rise_tdi[i]) if (i < 64) r[i] = rise_tdi[i];
        return r;
    endfunction

    // Reference model: each command expands into a list of per-clk pin values.
    typedef struct {
        logic tck;
        logic tms;
        logic tdi;
        int   cap;
    } cyc_t;

    cyc_t        wave[$];
    int          m_st;
    bit          m_scan;
    logic        m_tck, m_tms, m_tdi;
    logic [31:0] m_rsp;

    function automatic cyc_t mk(input logic c, input logic m, input logic d, input int cap);
        cyc_t r;
        r.tck = c; r.tms = m; r.tdi = d; r.cap = cap;
        return r;
    endfunction

    function automatic int eff_len(input int l);
        return (l == 0) ? 1 : (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    function automatic void build(input int op, input int len, input logic [31:0] data, input bit lead);
        bit tl[$];
        int pre;
        wave.delete();
        if (lead) wave.push_back(mk(1'b0, 1'b0, 1'b0, -1));
        case (op)
            0: begin repeat (5) tl.push_back(1'b1); tl.push_back(1'b0); end
            1: begin tl.push_back(1'b1); tl.push_back(1'b1); tl.push_back(1'b0); tl.push_back(1'b0); end
            2: begin tl.push_back(1'b1); tl.push_back(1'b0); tl.push_back(1'b0); end
            default: ;
        endcase
        pre = tl.size();
        if (op == 1 || op == 2) begin
            for (int i = 0; i < len; i++) tl.push_back(i == len - 1);
            tl.push_back(1'b1);
            tl.push_back(1'b0);
        end
        if (op == 3) for (int i = 0; i < len; i++) tl.push_back(1'b0);
        foreach (tl[k]) begin
            bit   sh;
            logic d;
            sh = (op == 1 || op == 2) && k >= pre && k < pre + len;
            d  = sh ? data[k - pre] : 1'b0;
            wave.push_back(mk(1'b0, tl[k], d, -1));
            wave.push_back(mk(1'b1, tl[k], d, sh ? k - pre : -1));
        end
    endfunction

    function automatic void m_pop();
        cyc_t c;
        c = wave.pop_front();
        m_tck = c.tck; m_tms = c.tms; m_tdi = c.tdi;
        if (c.tck && c.cap >= 0) m_rsp[c.cap] = tdo;
    endfunction

    // m_st: 0 running a sequence, 1 waiting for a command, 2 holding a response.
    always @(negedge clk) begin
        if (reset) begin
            build(0, 0, 32'h0, 1'b0);
            m_pop();
            m_st = 0; m_scan = 1'b0; m_rsp = '0;
        end else begin
            case (m_st)
                0: begin
                    if (wave.size() == 0) begin
                        m_tck = 1'b0; m_tms = 1'b0; m_tdi = 1'b0;
                        m_st = m_scan ? 2 : 1;
                    end else begin
                        m_pop();
                    end
                end
                1: begin
                    if (cmd_valid) begin
                        build(int'(cmd_op), eff_len(int'(cmd_len)), cmd_data, 1'b1);
                        m_rsp  = '0;
                        m_scan = (cmd_op == 2'b01) || (cmd_op == 2'b10);
                        m_pop();
                        m_st = 0;
                    end
                end
                default: if (rsp_ready) m_st = 1;
            endcase
        end
        check("pins{tck,tms,tdi,busy,cmd_ready,rsp_valid}",
              64'({tck, tms, tdi, busy, cmd_ready, rsp_valid}),
              64'({m_tck, m_tms, m_tdi, m_st == 0, m_st == 1, m_st == 2}));
        if (m_st == 2) check("rsp_data", 64'(rsp_data), 64'(m_rsp));
    end

    task automatic wait_ready(input string name, input bit noise);
        int t = 0;
        while (!cmd_ready && t < 400) begin
            if (noise) rsp_ready = 1'($urandom);
            @(negedge clk); #1;
            t++;
        end
        rsp_ready = 1'b0;
        check({name, "_ready"}, 64'(cmd_ready), 64'(1));
        check({name, "_tap_in_rti"}, 64'(tap_st), 64'(RTI));
    endtask

    task automatic send(input int op, input int len, input logic [31:0] data);
        int t = 0;
        cmd_op = 2'(op); cmd_len = LW'(len); cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && t < 400) begin @(negedge clk); #1; t++; end
        check("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        cmd_len   = LW'($urandom);
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] d);
        int t = 0;
        while (!rsp_valid && t < 400) begin @(negedge clk); #1; t++; end
        check("rsp_valid_seen", 64'(rsp_valid), 64'(1));
        repeat (hold) begin @(negedge clk); #1; end
        d = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int t;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pins", 64'({tck, tms, tdi, busy, cmd_ready, rsp_valid}), 64'(6'b010100));
        check("reset_rsp_data", 64'(rsp_data), 64'(0));

        rise_tms.delete(); rise_tdi.delete();
        reset = 1'b0;
        wait_ready("por", 1'b0);
        check("por_rises", 64'(rise_tms.size()), 64'(6));
        check("por_tms", pack_tms(), 64'h1F);
        check("por_busy", 64'(busy), 64'(0));

        tdo_mode = 2;
        rise_tms.delete(); rise_tdi.delete();
        send(1, 4, 32'h2);
        get_rsp(0, d);
        check("ir4_rises", 64'(rise_tms.size()), 64'(10));
        check("ir4_tms", pack_tms(), 64'h183);
        check("ir4_tdi", pack_tdi(), 64'h020);
        check("ir4_rsp", 64'(d), 64'h0000000F);
        wait_ready("ir4", 1'b0);

        tdo_mode = 0;
        rise_tms.delete(); rise_tdi.delete();
        send(2, 8, 32'hA5);
        get_rsp(20, d);
        check("dr8_rises", 64'(rise_tms.size()), 64'(13));
        check("dr8_bypass_rsp", 64'(d), 64'h0000004A);
        wait_ready("dr8", 1'b0);

        rise_tms.delete(); rise_tdi.delete();
        send(3, 3, 32'hFFFF_FFFF);
        wait_ready("idle3", 1'b0);
        check("idle3_rises", 64'(rise_tms.size()), 64'(3));
        check("idle3_tms", pack_tms(), 64'h0);
        rise_tms.delete(); rise_tdi.delete();
        send(2, 0, $urandom);
        get_rsp(1, d);
        check("dr0_rises", 64'(rise_tms.size()), 64'(6));
        check("dr0_tms", pack_tms(), 64'h19);
        check("dr0_rsp_upper", 64'(d >> 1), 64'(0));
        wait_ready("dr0", 1'b0);

        tdo_mode = 2;
        rise_tms.delete(); rise_tdi.delete();
        send(1, 40, $urandom);
        get_rsp(2, d);
        check("ir_clamp_rises", 64'(rise_tms.size()), 64'(38));
        check("ir_clamp_rsp", 64'(d), 64'hFFFF_FFFF);
        wait_ready("ir_clamp", 1'b0);

        tdo_mode = 1;
        rise_tms.delete(); rise_tdi.delete();
        send(2, 16, $urandom);
        t = 0;
        while (rise_tms.size() < 9 && t < 100) begin @(negedge clk); #1; t++; end
        check("midscan_reached", 64'(rise_tms.size()), 64'(9));
        reset = 1'b1;
        #1;
        check("midscan_reset_pins", 64'({tck, tms, busy, cmd_ready, rsp_valid}), 64'(5'b01100));
        repeat (2) @(negedge clk);
        #1;
        rise_tms.delete(); rise_tdi.delete();
        reset = 1'b0;
        wait_ready("midscan_rerun", 1'b0);
        check("midscan_rerun_rises", 64'(rise_tms.size()), 64'(6));
        check("midscan_rerun_tms", pack_tms(), 64'h1F);

        for (int n = 0; n < 40; n++) begin
            tdo_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
            send($urandom_range(0, 3), $urandom_range(0, 40), $urandom);
            wait_ready("random", 1'b1);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before t=2000000");
        $fatal(1, "timeout");
    end

endmodule
